// File: rtl/pixel_packer.sv
// ---------------------------------------------------------------------------
// pixel_packer
//   Transmit-side 21->16 gearbox. Pixels are appended LSB-first to a 37-bit
//   bit buffer and leave it as 16-bit link words, so a 16->21 aligner on the
//   far side recovers the pixels bit-exactly. A flush zero-pads the frame
//   tail up to the next word boundary and drains the buffer.
//
// Ports
//   clk, rst        single clock, asynchronous active-high reset
//   pix_data/valid  pixel input (bit 0 goes out first), pix_ready handshake
//   flush_req       level request, edge-qualified: held high flushes once
//   flush_done      one-cycle pulse once the buffer is empty after a flush
//   out_data/valid  link word output, out_ready handshake
//   pix_count       pixels accepted since reset (wraps)
//   word_count      words emitted since reset (wraps)
// ---------------------------------------------------------------------------

// Run-time checks on the packer state.
module pixel_packer_chk (
    input logic       clk,
    input logic       rst,
    input logic [5:0] cnt,
    input logic       flush_done
);
    // The pix_ready rule must keep the buffer from overflowing.
    a_cnt_max: assert property (@(posedge clk) disable iff (rst) cnt <= 6'd36);
    // flush_done is a single-cycle pulse.
    a_done_pulse: assert property (@(posedge clk) disable iff (rst) flush_done |=> !flush_done);
endmodule

module pixel_packer #(
    parameter int PIX_W  = 21,
    parameter int WORD_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic              flush_req,
    output logic              flush_done,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  pix_count,
    output logic [CNT_W-1:0]  word_count
);
    localparam int BUF_W = PIX_W + WORD_W;

    typedef enum logic [0:0] {
        ST_STREAM = 1'b0,
        ST_FLUSH  = 1'b1
    } state_t;

    state_t             state_q;
    logic [BUF_W-1:0]   buf_q;
    logic [BUF_W-1:0]   buf_d;
    logic [BUF_W-1:0]   base_s;
    logic [5:0]         cnt_q;
    logic [5:0]         cnt_d;
    logic [5:0]         cbase_s;
    logic               valid_q;
    logic               done_q;
    logic               arm_q;
    logic [CNT_W-1:0]   pix_cnt_q;
    logic [CNT_W-1:0]   word_cnt_q;
    logic               pop_s;
    logic               push_s;
    logic               ready_s;

    assign pop_s   = valid_q & out_ready;
    // A pixel fits if the buffer holds at most 15 bits, or at most 31 bits
    // while a word is leaving in the same cycle.
    assign ready_s = (state_q == ST_STREAM) &
                     ((cnt_q <= 6'd15) | ((cnt_q <= 6'd31) & pop_s));
    assign push_s  = pix_valid & ready_s;

    // Next buffer contents: drop the departing word, then append the pixel.
    always_comb begin
        base_s  = buf_q;
        cbase_s = cnt_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        if (pop_s) begin
            base_s  = {{WORD_W{1'b0}}, buf_q[BUF_W-1:WORD_W]};
            cbase_s = cnt_q - 6'd16;
        end else begin
            base_s  = buf_q;
            cbase_s = cnt_q;
        end
        if (push_s) begin
            // cbase_s <= 15 whenever a push is allowed, so the pixel fits.
            buf_d = base_s | (BUF_W'(pix_data) << cbase_s);
            cnt_d = cbase_s + 6'd21;
        end else if ((state_q == ST_FLUSH) && (cnt_q != 6'd0) && (cnt_q < 6'd16)) begin
            // Zero pad: upper bits are already zero, only the count moves.
            buf_d = buf_q;
            cnt_d = 6'd16;
        end else begin
            buf_d = base_s;
            cnt_d = cbase_s;
        end
    end

    // Bit buffer, word-valid flag and statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q      <= {BUF_W{1'b0}};
            cnt_q      <= 6'd0;
            valid_q    <= 1'b0;
            pix_cnt_q  <= {CNT_W{1'b0}};
            word_cnt_q <= {CNT_W{1'b0}};
        end else begin
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            valid_q <= (cnt_d >= 6'd16);
            if (push_s) begin
                pix_cnt_q <= pix_cnt_q + CNT_W'(1'b1);
            end else begin
                pix_cnt_q <= pix_cnt_q;
            end
            if (pop_s) begin
                word_cnt_q <= word_cnt_q + CNT_W'(1'b1);
            end else begin
                word_cnt_q <= word_cnt_q;
            end
        end
    end

    // Stream/flush control with registered flush_done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_STREAM;
            done_q  <= 1'b0;
            arm_q   <= 1'b1;
        end else begin
            done_q <= 1'b0;
            // Re-arm only once the request has been seen low.
            arm_q  <= arm_q | ~flush_req;
            case (state_q)
                ST_STREAM: begin
                    if (flush_req && arm_q && !push_s) begin
                        state_q <= ST_FLUSH;
                        arm_q   <= 1'b0;
                    end else begin
                        state_q <= ST_STREAM;
                    end
                end
                ST_FLUSH: begin
                    if (cnt_q == 6'd0) begin
                        state_q <= ST_STREAM;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_FLUSH;
                    end
                end
                default: begin
                    state_q <= ST_STREAM;
                end
            endcase
        end
    end

    assign pix_ready  = ready_s;
    assign out_valid  = valid_q;
    assign out_data   = buf_q[WORD_W-1:0];
    assign flush_done = done_q;
    assign pix_count  = pix_cnt_q;
    assign word_count = word_cnt_q;

    pixel_packer_chk u_chk (
        .clk        (clk),
        .rst        (rst),
        .cnt        (cnt_q),
        .flush_done (done_q)
    );

endmodule

// File: tb/tb_pixel_packer.sv
// ---------------------------------------------------------------------------
// tb_pixel_packer
//   Table of per-cycle vectors for the basic push/flush/backpressure/reset
//   behaviour, then stream runs checked by recovering 21-bit pixels from the
//   emitted words, then reset-mid-flush and held-flush_req sequences.
// ---------------------------------------------------------------------------
module tb_pixel_packer;
    logic        clk;
    logic        rst;
    logic [20:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        flush_req;
    logic        flush_done;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pix_count;
    logic [31:0] word_count;

    int n_vec = 0;
    int n_err = 0;

    // Receive-aligner model state.
    logic [63:0] acc;
    int          acc_n;
    logic [20:0] exp_q[$];

    pixel_packer #(.PIX_W(21), .WORD_W(16), .CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pix_count  (pix_count),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        pv;
        logic [20:0] pd;
        logic        fr;
        logic        orr;
        logic        pr;
        logic        ov;
        logic [15:0] od;
        logic        fd;
        logic [31:0] pc;
        logic [31:0] wc;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(input logic r, input logic pv, input logic [20:0] pd,
                                input logic fr, input logic orr, input logic pr,
                                input logic ov, input logic [15:0] od, input logic fd,
                                input logic [31:0] pc, input logic [31:0] wc);
        vec_t v;
        v.rst = r; v.pv = pv; v.pd = pd; v.fr = fr; v.orr = orr;
        v.pr = pr; v.ov = ov; v.od = od; v.fd = fd; v.pc = pc; v.wc = wc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic pv, input logic [20:0] pd,
                         input logic fr, input logic orr);
        rst = r; pix_valid = pv; pix_data = pd; flush_req = fr; out_ready = orr;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 21'h0, 1'b0, 1'b0);
        next_cycle();
        drive(1'b0, 1'b0, 21'h0, 1'b0, 1'b0);
    endtask

    // Append a link word to the aligner and compare every completed pixel.
    task automatic take_word(input logic [15:0] w, input string tag);
        logic [20:0] got;
        logic [20:0] want;
        acc   = acc | (64'(w) << acc_n);
        acc_n = acc_n + 16;
        while (acc_n >= 21) begin
            got = acc[20:0];
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL %s_extra_pixel: got 0x%0h, want none", tag, got);
            end else begin
                want = exp_q.pop_front();
                chk({tag, "_pixel"}, 32'(got), 32'(want));
            end
            acc   = acc >> 21;
            acc_n = acc_n - 21;
        end
    endtask

    task automatic run_stream(input int npix, input int pv_pct, input int or_pct, input string tag);
        int          sent;
        int          cyc;
        int          starved;
        int          fw;
        int          fd_seen;
        int          exp_words;
        int          exp_flush;
        logic        done;
        logic        primed;
        logic        stall;
        logic        pushed;
        logic [15:0] prev_od;
        logic [20:0] cur;
        acc = 64'h0; acc_n = 0; exp_q.delete();
        sent = 0; cyc = 0; starved = 0; done = 1'b0; primed = 1'b0;
        stall = 1'b0; prev_od = 16'h0;
        exp_words = (npix * 21 + 15) / 16;
        exp_flush = exp_words - (npix * 21) / 16;
        cur = 21'($urandom);
        do_reset();
        while (!done && cyc < 10000) begin
            rst       = 1'b0;
            flush_req = 1'b0;
            pix_data  = cur;
            pix_valid = (sent < npix) && (int'($urandom_range(99)) < pv_pct);
            out_ready = (sent >= npix) || (int'($urandom_range(99)) < or_pct);
            @(negedge clk);
            if (stall) chk({tag, "_stall_hold"}, 32'(out_data), 32'(prev_od));
            if (out_valid) primed = 1'b1;
            if (primed && sent < npix && !out_valid) starved++;
            if (out_valid && out_ready) take_word(out_data, tag);
            pushed = pix_valid && pix_ready;
            if (pushed) begin
                exp_q.push_back(cur);
                sent++;
                cur = 21'($urandom);
            end
            if (sent == npix && !pushed && !out_valid) done = 1'b1;
            stall   = out_valid && !out_ready;
            prev_od = out_data;
            next_cycle();
            cyc++;
        end
        chk({tag, "_drained_in_budget"}, 32'(done), 32'd1);
        // Flush the tail and collect any padded word.
        fw = 0; fd_seen = 0;
        drive(1'b0, 1'b0, 21'h0, 1'b1, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                take_word(out_data, tag);
                fw++;
            end
            if (flush_done) fd_seen++;
            next_cycle();
            flush_req = 1'b0;
        end
        chk({tag, "_flush_words"}, 32'(fw), 32'(exp_flush));
        chk({tag, "_flush_done_cnt"}, 32'(fd_seen), 32'd1);
        chk({tag, "_pix_count"}, pix_count, 32'(npix));
        chk({tag, "_word_count"}, word_count, 32'(exp_words));
        chk({tag, "_pixels_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_pad_zero"}, acc[31:0], 32'd0);
        if (pv_pct == 100 && or_pct == 100) chk({tag, "_no_starve"}, 32'(starved), 32'd0);
    endtask

    initial begin
        int   s;
        int   fdc;
        logic fin;
        logic pushed;
        drive(1'b1, 1'b0, 21'h0, 1'b0, 1'b0);

        //                 rst   pv    pd          fr    or    pr    ov    od        fd    pc     wc
        tbl[0]  = mk(1'b1, 1'b0, 21'h000000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 32'd0, 32'd0);
        tbl[1]  = mk(1'b0, 1'b1, 21'h1ABCDE, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 32'd0, 32'd0);
        tbl[2]  = mk(1'b0, 1'b1, 21'h000001, 1'b0, 1'b1, 1'b1, 1'b1, 16'hBCDE, 1'b0, 32'd1, 32'd0);
        tbl[3]  = mk(1'b0, 1'b0, 21'h000000, 1'b1, 1'b1, 1'b1, 1'b1, 16'h003A, 1'b0, 32'd2, 32'd1);
        tbl[4]  = mk(1'b0, 1'b0, 21'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 32'd2, 32'd2);
        tbl[5]  = mk(1'b0, 1'b0, 21'h000000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 32'd2, 32'd2);
        tbl[6]  = mk(1'b0, 1'b0, 21'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 32'd2, 32'd3);
        tbl[7]  = mk(1'b0, 1'b0, 21'h000000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 32'd2, 32'd3);
        tbl[8]  = mk(1'b0, 1'b0, 21'h000000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 32'd2, 32'd3);
        tbl[9]  = mk(1'b0, 1'b1, 21'h155555, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 32'd2, 32'd3);
        tbl[10] = mk(1'b0, 1'b1, 21'h0AAAAA, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5555, 1'b0, 32'd3, 32'd3);
        tbl[11] = mk(1'b0, 1'b1, 21'h0AAAAA, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5555, 1'b0, 32'd3, 32'd3);
        tbl[12] = mk(1'b0, 1'b1, 21'h0AAAAA, 1'b0, 1'b1, 1'b1, 1'b1, 16'h5555, 1'b0, 32'd3, 32'd3);
        tbl[13] = mk(1'b0, 1'b0, 21'h000000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h5555, 1'b0, 32'd4, 32'd4);
        tbl[14] = mk(1'b0, 1'b0, 21'h000000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0155, 1'b0, 32'd4, 32'd5);
        tbl[15] = mk(1'b1, 1'b0, 21'h000000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 32'd0, 32'd0);
        tbl[16] = mk(1'b0, 1'b1, 21'h000003, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 32'd0, 32'd0);
        tbl[17] = mk(1'b0, 1'b0, 21'h000000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0003, 1'b0, 32'd1, 32'd0);
        tbl[18] = mk(1'b0, 1'b0, 21'h000000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 32'd1, 32'd1);

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].rst, tbl[i].pv, tbl[i].pd, tbl[i].fr, tbl[i].orr);
            @(negedge clk);
            chk($sformatf("row%0d_pix_ready", i),  32'(pix_ready),  32'(tbl[i].pr));
            chk($sformatf("row%0d_out_valid", i),  32'(out_valid),  32'(tbl[i].ov));
            chk($sformatf("row%0d_out_data", i),   32'(out_data),   32'(tbl[i].od));
            chk($sformatf("row%0d_flush_done", i), 32'(flush_done), 32'(tbl[i].fd));
            chk($sformatf("row%0d_pix_count", i),  pix_count,       tbl[i].pc);
            chk($sformatf("row%0d_word_count", i), word_count,      tbl[i].wc);
            next_cycle();
        end

        // Full-rate 16 pixels: exactly 21 words, nothing left for the flush.
        run_stream(16, 100, 100, "full16");

        // Reset while flushing with 9 bits buffered (5 pixels in, 6 words out).
        do_reset();
        s = 0; fin = 1'b0;
        for (int k = 0; k < 40 && !fin; k++) begin
            drive(1'b0, (s < 5), 21'h0F0F0F ^ 21'(s), 1'b0, 1'b1);
            @(negedge clk);
            pushed = pix_valid && pix_ready;
            if (pushed) s++;
            if (s == 5 && !pushed && !out_valid) fin = 1'b1;
            next_cycle();
        end
        chk("rstflush_drained", 32'(fin), 32'd1);
        drive(1'b0, 1'b0, 21'h0, 1'b1, 1'b1);
        @(negedge clk);
        chk("rstflush_pre_pix_count", pix_count, 32'd5);
        chk("rstflush_pre_word_count", word_count, 32'd6);
        next_cycle();
        drive(1'b1, 1'b0, 21'h0, 1'b0, 1'b1);
        @(negedge clk);
        chk("rstflush_out_valid", 32'(out_valid), 32'd0);
        chk("rstflush_pix_ready", 32'(pix_ready), 32'd1);
        chk("rstflush_pix_count", pix_count, 32'd0);
        chk("rstflush_word_count", word_count, 32'd0);
        chk("rstflush_flush_done", 32'(flush_done), 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 21'h0, 1'b0, 1'b1);
        @(negedge clk);
        chk("rstflush_after_done", 32'(flush_done), 32'd0);
        chk("rstflush_after_valid", 32'(out_valid), 32'd0);
        next_cycle();
        drive(1'b0, 1'b1, 21'h1FFFFF, 1'b0, 1'b0);
        @(negedge clk);
        chk("fresh_pix_ready", 32'(pix_ready), 32'd1);
        next_cycle();
        drive(1'b0, 1'b0, 21'h0, 1'b0, 1'b1);
        @(negedge clk);
        chk("fresh_word_valid", 32'(out_valid), 32'd1);
        chk("fresh_word_data", 32'(out_data), 32'h0000FFFF);
        next_cycle();
        @(negedge clk);
        chk("fresh_tail_valid", 32'(out_valid), 32'd0);
        chk("fresh_tail_bits", 32'(out_data), 32'h0000001F);
        next_cycle();

        // flush_req together with a push, then held high.
        do_reset();
        drive(1'b0, 1'b1, 21'h012345, 1'b1, 1'b1);
        @(negedge clk);
        chk("fpush_accept", 32'(pix_ready), 32'd1);
        chk("fpush_c0_valid", 32'(out_valid), 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 21'h0, 1'b1, 1'b1);
        @(negedge clk);
        chk("fpush_c1_ready", 32'(pix_ready), 32'd1);
        chk("fpush_c1_data", 32'(out_data), 32'h00002345);
        chk("fpush_c1_valid", 32'(out_valid), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("fpush_c2_ready", 32'(pix_ready), 32'd0);
        chk("fpush_c2_valid", 32'(out_valid), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("fpush_pad_valid", 32'(out_valid), 32'd1);
        chk("fpush_pad_data", 32'(out_data), 32'h00000001);
        chk("fpush_pad_ready", 32'(pix_ready), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("fpush_c4_valid", 32'(out_valid), 32'd0);
        chk("fpush_c4_done", 32'(flush_done), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("fpush_done", 32'(flush_done), 32'd1);
        chk("fpush_done_ready", 32'(pix_ready), 32'd1);
        next_cycle();
        fdc = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (flush_done) fdc++;
            next_cycle();
        end
        chk("fheld_no_repeat", 32'(fdc), 32'd0);
        flush_req = 1'b0;
        next_cycle();
        flush_req = 1'b1;
        fdc = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (flush_done) fdc++;
            next_cycle();
        end
        chk("frearm_one_done", 32'(fdc), 32'd1);
        chk("frearm_no_word", word_count, 32'd2);
        flush_req = 1'b0;

        // Random handshakes on both sides over 1000 pixels.
        run_stream(1000, 50, 50, "rand1000");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
